// File: rtl/ifetch_sequencer.sv
// Instruction fetch controller: one outstanding word read, prefetch FIFO, decode handshake.
// Optional macro FETCH_BOUND_EN enables the fetch-window check and the sticky fetch_fault flag.
module ifetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h00400000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BOUND_LO   = 32'h00400000,
  parameter logic [31:0] BOUND_HI   = 32'h00400400
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        fetch_ready,
  output logic [31:0] instr_count,
  output logic        fetch_fault
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     pc_reg, pc_next;
  logic [31:0]     addr_reg, addr_next;
  logic            fault_reg, fault_next;
  logic [31:0]     instr_mem [FIFO_DEPTH];
  logic [31:0]     pc_mem    [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next, remain;
  logic            valid_reg;
  logic [31:0]     instr_reg, instr_next, hpc_reg, hpc_next;
  logic [31:0]     icount_reg;
  logic            push, pop, room, in_window;
  logic            unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];
  assign room       = count_reg < CW'(FIFO_DEPTH);

`ifdef FETCH_BOUND_EN
  assign in_window   = (pc_reg >= BOUND_LO) && (pc_reg <= BOUND_HI);
  assign fetch_fault = fault_reg;
`else
  logic unused_bounds;
  assign unused_bounds = ^{BOUND_LO, BOUND_HI};
  assign in_window     = 1'b1;
  assign fetch_fault   = 1'b0;
`endif

  // Control FSM; a redirect always wins the pc, whatever the state.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    addr_next  = addr_reg;
    fault_next = fault_reg;
    push       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!redirect && room && !fault_reg) begin
          if (in_window) begin
            state_next = REQ;
            addr_next  = pc_reg;
          end else begin
            fault_next = 1'b1;
          end
        end
      end
      REQ: begin
        if (imem_ack) begin
          state_next = IDLE;
          if (!redirect) begin
            push    = 1'b1;
            pc_next = pc_reg + 32'd4;
          end
        end else if (redirect) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (redirect) pc_next = {redirect_pc[31:2], 2'b00};
  end

  // FIFO bookkeeping; head registers are loaded with the post-update head so they are registered outputs.
  always_comb begin
    pop         = valid_reg & fetch_ready;
    remain      = count_reg - CW'(pop);
    rd_ptr_next = rd_ptr_reg + AW'(pop);
    count_next  = remain + CW'(push);
    if (redirect) begin
      count_next  = '0;
      rd_ptr_next = wr_ptr_reg;
    end
    instr_next = instr_reg;
    hpc_next   = hpc_reg;
    if (count_next != '0) begin
      if (remain == '0) begin
        instr_next = imem_rdata;
        hpc_next   = pc_reg;
      end else begin
        instr_next = instr_mem[rd_ptr_next];
        hpc_next   = pc_mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]    <= pc_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      addr_reg   <= RESET_PC;
      fault_reg  <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      instr_reg  <= '0;
      hpc_reg    <= '0;
      icount_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      addr_reg   <= addr_next;
      fault_reg  <= fault_next;
      wr_ptr_reg <= wr_ptr_reg + AW'(push);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      valid_reg  <= (count_next != '0);
      instr_reg  <= instr_next;
      hpc_reg    <= hpc_next;
      if (pop) icount_reg <= icount_reg + 32'd1;
    end
  end

  assign imem_req    = (state_reg != IDLE);
  assign imem_addr   = addr_reg;
  assign fetch_valid = valid_reg;
  assign fetch_instr = instr_reg;
  assign fetch_pc    = hpc_reg;
  assign instr_count = icount_reg;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Self-checking bench for ifetch_sequencer: memory responder plus a stream-level reference model.
module tb_ifetch_sequencer;

  localparam logic [31:0] RPC   = 32'h00400000;
  localparam int          DEPTH = 4;
`ifdef FETCH_BOUND_EN
  localparam logic [31:0] BHI = 32'h00400008;
`else
  localparam logic [31:0] BHI = 32'h00400400;
`endif

  logic        clk, reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_valid, fetch_ready, fetch_fault;
  logic [31:0] fetch_instr, fetch_pc, instr_count;

  ifetch_sequencer #(
    .RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .BOUND_LO(RPC), .BOUND_HI(BHI)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .instr_count(instr_count), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model: expected delivered stream, expected next request address, buffered words.
  int          occ;
  logic [31:0] exp_pc, exp_req, out_addr, hs_count, hold_pc, hold_instr;
  bit          outstanding, poisoned, hold;
  int          lat_left, lat_mode, new_reqs;
  logic [31:0] req_log [3];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    occ = 0; exp_pc = RPC; exp_req = RPC; out_addr = '0; hs_count = '0;
    outstanding = 0; poisoned = 0; hold = 0; lat_left = 0; new_reqs = 0;
  endtask

  // Called at a falling edge: check outputs, then play the memory side.
  task automatic sample_and_drive();
    redirect = 1'b0;
    chk("valid_vs_occ", 32'(fetch_valid), 32'(occ != 0));
    chk("instr_count", instr_count, hs_count);
`ifndef FETCH_BOUND_EN
    chk("fault_tied", 32'(fetch_fault), 32'd0);
`endif
    if (hold) begin
      chk("hold_pc", fetch_pc, hold_pc);
      chk("hold_instr", fetch_instr, hold_instr);
    end
    if (outstanding) begin
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_stable", imem_addr, out_addr);
    end else if (imem_req) begin
      chk("req_addr", imem_addr, exp_req);
      chk("req_room", 32'(occ < DEPTH), 32'd1);
      outstanding = 1;
      out_addr    = imem_addr;
      if (new_reqs < 3) req_log[new_reqs] = imem_addr;
      new_reqs++;
      lat_left = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
    end
    if (outstanding && lat_left == 0) begin
      imem_ack   = 1'b1;
      imem_rdata = word(out_addr);
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (outstanding) lat_left--;
    end
  endtask

  // Advance the model across the next rising edge, then return at the following falling edge.
  task automatic edge_step();
    bit hs, done;
    hs   = fetch_valid && fetch_ready;
    done = outstanding && imem_ack;
    if (hs) begin
      chk("hs_pc", fetch_pc, exp_pc);
      chk("hs_instr", fetch_instr, word(exp_pc));
      exp_pc   = exp_pc + 32'd4;
      hs_count = hs_count + 32'd1;
      occ--;
    end
    hold       = fetch_valid && !fetch_ready && !redirect;
    hold_pc    = fetch_pc;
    hold_instr = fetch_instr;
    if (done) begin
      outstanding = 0;
      if (redirect || poisoned) poisoned = 0;
      else begin
        occ++;
        exp_req = out_addr + 32'd4;
      end
    end
    if (redirect) begin
      occ     = 0;
      exp_pc  = {redirect_pc[31:2], 2'b00};
      exp_req = exp_pc;
      if (outstanding) poisoned = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    sample_and_drive();
    edge_step();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
  task automatic apply_reset();
    #2;
    reset = 1'b1; imem_ack = 1'b0; redirect = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_instr", fetch_instr, 32'd0);
    chk("rst_pc", fetch_pc, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_new_req(input string tag, input logic [31:0] addr);
    int start, n;
    start = new_reqs;
    n = 0;
    sample_and_drive();
    while (new_reqs == start && n < 50) begin
      edge_step();
      sample_and_drive();
      n++;
    end
    chk(tag, imem_addr, addr);
    edge_step();
  endtask

  initial begin
    int n;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    redirect_pc = '0; fetch_ready = 1'b0; lat_mode = 1;
    model_reset();
    @(negedge clk);
    apply_reset();

`ifdef FETCH_BOUND_EN
    fetch_ready = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk("bound_reqs", new_reqs, 32'd3);
    chk("bound_a0", req_log[0], 32'h00400000);
    chk("bound_a1", req_log[1], 32'h00400004);
    chk("bound_a2", req_log[2], 32'h00400008);
    chk("bound_fault", 32'(fetch_fault), 32'd1);
    chk("bound_req_idle", 32'(imem_req), 32'd0);
    chk("bound_count", instr_count, 32'd3);
    redirect_pc = RPC;
    sample_and_drive();
    redirect = 1'b1;
    edge_step();
    for (int i = 0; i < 10; i++) step();
    chk("bound_sticky", 32'(fetch_fault), 32'd1);
    chk("bound_no_req", 32'(imem_req), 32'd0);
`else
    // Streaming with a one-cycle memory and decode always ready.
    fetch_ready = 1'b1;
    n = 0;
    while (hs_count < 3 && n < 40) begin step(); n++; end
    chk("seq_hs", hs_count, 32'd3);
    chk("seq_a0", req_log[0], 32'h00400000);
    chk("seq_a1", req_log[1], 32'h00400004);
    chk("seq_a2", req_log[2], 32'h00400008);
    chk("seq_count", instr_count, 32'd3);

    // Stalled decode fills the FIFO and stops issue; one pop frees exactly one slot.
    apply_reset();
    fetch_ready = 1'b0; lat_mode = 0;
    for (int i = 0; i < 30; i++) step();
    chk("fill_reqs", new_reqs, 32'd4);
    chk("fill_req_idle", 32'(imem_req), 32'd0);
    chk("fill_valid", 32'(fetch_valid), 32'd1);
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("refill_reqs", new_reqs, 32'd5);
    chk("refill_count", instr_count, 32'd1);
    chk("refill_req_idle", 32'(imem_req), 32'd0);

    // Redirect while a slow read is pending: read drains, data dropped.
    apply_reset();
    fetch_ready = 1'b1; lat_mode = 3;
    n = 0;
    sample_and_drive();
    while (!(new_reqs >= 2 && imem_req && !imem_ack) && n < 60) begin
      edge_step(); sample_and_drive(); n++;
    end
    chk("drain_found", 32'(imem_req && !imem_ack), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h00400083;
    edge_step();
    chk("drain_flush", 32'(fetch_valid), 32'd0);
    wait_new_req("drain_next_addr", 32'h00400080);

    // Redirect coincident with ack: no push, next read at the target.
    lat_mode = 2;
    n = 0;
    sample_and_drive();
    while (!imem_ack && n < 60) begin edge_step(); sample_and_drive(); n++; end
    chk("coinc_found", 32'(imem_ack), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h00400200;
    edge_step();
    chk("coinc_flush", 32'(fetch_valid), 32'd0);
    wait_new_req("coinc_next_addr", 32'h00400200);

    // Random latency, back-pressure and redirects against the model.
    lat_mode = -1;
    for (int i = 0; i < 800; i++) begin
      sample_and_drive();
      fetch_ready = ($urandom_range(9, 0) < 7);
      if ($urandom_range(24, 0) == 0) begin
        redirect    = 1'b1;
        redirect_pc = RPC + (32'($urandom_range(255, 0)) << 2) + 32'($urandom_range(3, 0));
      end
      edge_step();
    end

    // Reset while a read is pending with two words buffered.
    apply_reset();
    fetch_ready = 1'b0; lat_mode = 2;
    n = 0;
    sample_and_drive();
    while (!(occ == 2 && outstanding && !imem_ack) && n < 60) begin
      edge_step(); sample_and_drive(); n++;
    end
    chk("midreq_found", 32'(occ == 2 && imem_req), 32'd1);
    apply_reset();
    lat_mode = 1;
    wait_new_req("post_reset_addr", RPC);
    chk("post_reset_count", instr_count, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
